// File: rtl/imm_pkg.sv
// Shared types for the immediate-generator pipeline: format encodings,
// the legal-width check and the payload held by the output and skid registers.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I     = 3'b000,
        IMM_U     = 3'b001,
        IMM_B     = 3'b010,
        IMM_J     = 3'b011,
        IMM_S     = 3'b100,
        IMM_SHAMT = 3'b101,
        IMM_ZIMM  = 3'b110,
        IMM_NONE  = 3'b111
    } imm_src_e;

    localparam int unsigned XLEN_MAX = 64;

    function automatic bit xlen_legal(input int unsigned xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

    // Sized for the widest legal XLEN; narrower builds leave the top half at zero.
    typedef struct packed {
        logic [XLEN_MAX-1:0] imm;
        logic [XLEN_MAX-1:0] target;
    } imm_stage_t;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Decode-side and execute-side handshake bundle of the immediate generator.
interface imm_gen_pipe_if
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
);

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     Instr;
    logic [2:0]      ImmSrc;
    logic [XLEN-1:0] PC;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] ImmOp;
    logic [XLEN-1:0] Target;

    modport master (
        output flush, in_valid, Instr, ImmSrc, PC, out_ready,
        input  in_ready, out_valid, ImmOp, Target
    );

    modport slave (
        input  flush, in_valid, Instr, ImmSrc, PC, out_ready,
        output in_ready, out_valid, ImmOp, Target
    );

endinterface

// File: rtl/imm_expand.sv
// Combinational immediate expansion of a 32-bit RISC-V instruction word to XLEN bits.
module imm_expand
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     Instr,
    input  logic [2:0]      ImmSrc,
    output logic [XLEN-1:0] ImmOp
);

    logic [31:0] imm_i, imm_u, imm_b, imm_j, imm_s;
    logic [5:0]  shamt;
    logic        sgn;
    logic        unused_opcode;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] zext6(input logic [5:0] v);
        logic [XLEN-1:0] r;
        r      = '0;
        r[5:0] = v;
        return r;
    endfunction

    assign sgn   = Instr[31];
    assign imm_i = {{20{sgn}}, Instr[31:20]};
    assign imm_u = {Instr[31:12], 12'b0};
    assign imm_b = {{20{sgn}}, Instr[7], Instr[30:25], Instr[11:8], 1'b0};
    assign imm_j = {{12{sgn}}, Instr[19:12], Instr[20], Instr[30:21], 1'b0};
    assign imm_s = {{20{sgn}}, Instr[31:25], Instr[11:7]};
    // RV64 shifts take a 6-bit shamt; RV32 ignores bit 25.
    assign shamt = (XLEN == 64) ? Instr[25:20] : {1'b0, Instr[24:20]};

    assign unused_opcode = ^Instr[6:0];

    always_comb begin
        ImmOp = '0;
        case (imm_src_e'(ImmSrc))
            IMM_I:     ImmOp = sext32(imm_i);
            IMM_U:     ImmOp = sext32(imm_u);
            IMM_B:     ImmOp = sext32(imm_b);
            IMM_J:     ImmOp = sext32(imm_j);
            IMM_S:     ImmOp = sext32(imm_s);
            IMM_SHAMT: ImmOp = zext6(shamt);
            IMM_ZIMM:  ImmOp = zext6({1'b0, Instr[19:15]});
            default:   ImmOp = '0;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate expansion plus PC-relative target, behind a valid/ready
// handshake with a one-entry skid buffer so back-pressure never drops an instruction.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input logic          clk,
    input logic          rst,
    imm_gen_pipe_if.slave bus
);

    if (!xlen_legal(XLEN)) begin : g_xlen_check
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    imm_stage_t      fresh;
    imm_stage_t      or_q, or_d;
    imm_stage_t      sk_q, sk_d;
    logic            or_v_q, or_v_d;
    logic            sk_v_q, sk_v_d;
    logic            accept;
    logic            in_xfer;
    logic            out_xfer;

    imm_expand #(
        .XLEN(XLEN)
    ) u_expand (
        .Instr (bus.Instr),
        .ImmSrc(bus.ImmSrc),
        .ImmOp (imm)
    );

    assign target = bus.PC + imm;
    assign fresh  = '{imm: XLEN_MAX'(imm), target: XLEN_MAX'(target)};

    // Ready depends only on registered state, keeping out_ready off the input path.
    assign accept   = !rst && !sk_v_q;
    assign in_xfer  = bus.in_valid && accept;
    assign out_xfer = or_v_q && bus.out_ready;

    always_comb begin
        or_d   = or_q;
        sk_d   = sk_q;
        or_v_d = or_v_q;
        sk_v_d = sk_v_q;
        if (bus.flush) begin
            or_v_d = 1'b0;
            sk_v_d = 1'b0;
        end else if (!or_v_q) begin
            if (in_xfer) begin
                or_d   = fresh;
                or_v_d = 1'b1;
            end
        end else if (!sk_v_q) begin
            if (in_xfer && out_xfer) begin
                or_d = fresh;
            end else if (in_xfer) begin
                sk_d   = fresh;
                sk_v_d = 1'b1;
            end else if (out_xfer) begin
                or_v_d = 1'b0;
            end
        end else if (out_xfer) begin
            or_d   = sk_q;
            sk_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            or_q   <= '0;
            sk_q   <= '0;
            or_v_q <= 1'b0;
            sk_v_q <= 1'b0;
        end else begin
            or_q   <= or_d;
            sk_q   <= sk_d;
            or_v_q <= or_v_d;
            sk_v_q <= sk_v_d;
        end
    end

    assign bus.in_ready  = accept;
    assign bus.out_valid = or_v_q;
    assign bus.ImmOp     = or_q.imm[XLEN-1:0];
    assign bus.Target    = or_q.target[XLEN-1:0];

endmodule
